// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, WIDTH steps.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz;

  logic op_md, op_mf, op_mt;
  logic unit_en, unit_op;
  logic accept, mt_wr;

  always_comb begin
    op_md = 1'b0;
    op_mf = 1'b0;
    op_mt = 1'b0;
    unique case (funct)
      6'b011000,
      6'b011001,
      6'b011010,
      6'b011011: op_md = 1'b1;
      6'b010000,
      6'b010010: op_mf = 1'b1;
      6'b010001,
      6'b010011: op_mt = 1'b1;
      default: ;
    endcase
  end

  assign unit_en = start & (alu_op == 2'b10);
  assign unit_op = unit_en & (op_md | op_mf | op_mt);
  assign busy    = (state != IDLE);
  assign stall   = unit_op & busy;
  assign accept  = unit_en & op_md & ~busy;
  assign mt_wr   = unit_en & op_mt & ~busy;
  assign rd_data = funct[1] ? lo : hi;

  // funct[0]=0 selects the signed variant, funct[1]=1 selects divide
  logic             sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sgn   = ~funct[0];
  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               ge;
  logic [2*WIDTH-1:0] div_nx;

  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx   = {add_sum, acc[WIDTH-1:1]};
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign ge       = (rem_sh >= {1'b0, opnd});
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd;
  assign div_nx   = {ge ? rem_diff : rem_sh[WIDTH-1:0],
                     acc[WIDTH-2:0], ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign prod = neg_lo ? -acc : acc;
  assign quo  = dz ? '1 :
                neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH]
                       : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            is_div <= funct[1];
            cnt    <= CW'(WIDTH - 1);
            dz     <= funct[1] & (src_b == '0);
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            if (funct[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else if (mt_wr) begin
            if (funct[1]) lo <= src_a;
            else          hi <= src_a;
          end
        end
        RUN: begin
          acc <= is_div ? div_nx : mul_nx;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Table vectors, random ops vs model, stall and reset sequences.
module tb_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b;
  logic [31:0] rd_data;
  logic        busy, done, stall;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .alu_op (alu_op),
    .funct  (funct),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_data(rd_data),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference from plain 64-bit arithmetic: returns {hi, lo}
  function automatic logic [63:0] model(input logic [5:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = '0;
    case (f)
      F_MULTU: p = {32'd0, a} * {32'd0, b};
      F_MULT:  p = sa * sb;
      F_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
      F_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic read_hilo(output logic [31:0] hi,
                           output logic [31:0] lo);
    funct = F_MFHI;
    #1 hi = rd_data;
    funct = F_MFLO;
    #1 lo = rd_data;
  endtask

  task automatic do_op(input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output int n, output logic pulse);
    @(negedge clk);
    start  = 1'b1;
    alu_op = 2'b10;
    funct  = f;
    src_a  = a;
    src_b  = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    pulse = done;
    read_hilo(hi, lo);
    @(negedge clk);
    pulse = pulse & ~done;
  endtask

  initial begin
    logic [31:0] hi, lo, a, b, cur_lo;
    logic [63:0] exp;
    logic [5:0]  f;
    logic        pulse;
    int          n;

    vt[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001};
    vt[1] = '{F_MULT, 32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[2] = '{F_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000};
    vt[4] = '{F_DIVU, 32'h0000_1234, 32'd0,
              32'h0000_1234, 32'hFFFF_FFFF};
    vt[5] = '{F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
    vt[6] = '{F_MULT, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000};
    vt[7] = '{F_DIV, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD};

    rstn   = 1'b0;
    start  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MULT;
    src_a  = '0;
    src_b  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    start = 1'b0;
    read_hilo(hi, lo);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    start = 1'b1;
    funct = F_MTHI;
    src_a = 32'hA5A5_A5A5;
    @(negedge clk);
    funct = F_MFHI;
    #1;
    chk("mthi_rd", rd_data, 32'hA5A5_A5A5);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    chk("mfhi_stall", stall, 0);
    funct = F_MFLO;
    #1 chk("mflo_zero", rd_data, 0);
    start = 1'b0;

    @(negedge clk);
    start = 1'b1;
    funct = F_MTLO;
    src_a = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    read_hilo(hi, lo);
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi", hi, 32'hA5A5_A5A5);

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].f, vt[i].a, vt[i].b, hi, lo, n, pulse);
      chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("vec%0d_lat", i), n, 33);
      chk($sformatf("vec%0d_done", i), pulse, 1);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 300);
      if ($urandom_range(0, 5) == 0) b = -$urandom_range(1, 300);
      exp = model(f, a, b);
      do_op(f, a, b, hi, lo, n, pulse);
      chk($sformatf("rnd%0d_hi f=%b a=%h b=%h", i, f, a, b),
          hi, exp[63:32]);
      chk($sformatf("rnd%0d_lo f=%b a=%h b=%h", i, f, a, b),
          lo, exp[31:0]);
      chk($sformatf("rnd%0d_lat", i), n, 33);
    end

    exp    = model(F_MULTU, vt[7].a, vt[7].b);
    exp    = {vt[7].hi, vt[7].lo};
    a      = 32'h0001_2345;
    b      = 32'hFFFF_F777;
    do_op(F_DIVU, 32'd1000, 32'd3, hi, lo, n, pulse);
    cur_lo = 32'd333;
    @(negedge clk);
    start  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MULT;
    src_a  = a;
    src_b  = b;
    @(negedge clk);
    n = 0;
    while (busy && n < 200) begin
      n++;
      funct = F_MFLO;
      #1;
      chk("bsy_mflo_stall", stall, 1);
      chk("bsy_lo_hold", rd_data, cur_lo);
      funct = F_ADD;
      #1 chk("bsy_add_stall", stall, 0);
      funct = F_MTHI;
      src_a = 32'hDEAD_BEEF;
      #1 chk("bsy_mthi_stall", stall, 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("bsy_lat", n, 33);
    chk("bsy_done", done, 1);
    chk("bsy_stall_off", stall, 0);
    exp = model(F_MULT, a, b);
    read_hilo(hi, lo);
    chk("bsy_hi", hi, exp[63:32]);
    chk("bsy_lo", lo, exp[31:0]);

    @(negedge clk);
    start = 1'b1;
    funct = F_DIV;
    src_a = 32'h7654_3210;
    src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    read_hilo(hi, lo);
    chk("mid_hi", hi, 0);
    chk("mid_lo", lo, 0);
    @(negedge clk);
    rstn = 1'b1;
    do_op(F_MULTU, 32'd5, 32'd6, hi, lo, n, pulse);
    chk("post_hi", hi, 0);
    chk("post_lo", lo, 30);
    chk("post_lat", n, 33);
    chk("post_done", pulse, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
